fp32_divsqrt_issuer: RTL and testbench
======================================

FP32_DIVSQRT_ISSUER -- requirements
Module: fp32_divsqrt_issuer

Interface
REQ-001 SHALL have port clock, in, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, in, 1: one clock; reset is asynchronous and active-high.
REQ-003 SHALL have request inputs req_valid (1), req_sqrt (1), req_rm (3), req_tininess (1), req_a (32, IEEE fp32), req_b (32, IEEE fp32; ignored when req_sqrt=1).
REQ-004 SHALL have request output req_ready (1).
REQ-005 SHALL have engine-facing outputs ds_in_valid (1), ds_sqrt (1), ds_rm (3), ds_tininess (1), ds_a (33, recoded), ds_b (33, recoded).
REQ-006 SHALL have engine-facing inputs ds_in_ready (1), ds_out_valid_div (1), ds_out_valid_sqrt (1), ds_out (33, recoded), ds_flags (5, {NV,DZ,OF,UF,NX}).
REQ-007 SHALL have response outputs resp_valid (1), resp_data (32, IEEE), resp_flags (5), resp_sqrt (1), and input resp_ready (1).
REQ-008 SHALL have status outputs busy (1) and timeout (1).

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-010 IDLE: req_ready=1; req_valid -> capture all req_* fields, go to ISSUE.
REQ-011 ISSUE: ds_in_valid=1 with captured fields, a/b converted IEEE->recoded; ds_in_ready=1 -> go to WAIT; else hold all ds_* stable.
REQ-012 WAIT: ds_in_valid=0; the out-valid matching the captured op (div or sqrt) -> capture ds_out converted recoded->IEEE plus ds_flags, go to RESP.
REQ-013 Non-matching out-valid in WAIT, and any out-valid in IDLE, ISSUE or RESP, SHALL be ignored.
REQ-014 RESP: resp_valid=1, fields held stable; resp_ready=1 -> go to IDLE; no new request accepted in that same cycle.
REQ-015 req_ready SHALL be 1 only in IDLE; busy SHALL be 1 in every state except IDLE.
REQ-016 Latency: ds_in_valid asserts the cycle after acceptance; resp_valid asserts the cycle after the matching out-valid.
REQ-017 Recode: zero -> exp field 000; subnormals normalised; inf -> 110; NaN -> 111 with payload kept; recoded 1.0 = 33'h080000000.
REQ-018 Decode: a NaN result SHALL yield sign-preserved quiet NaN 0x7FC00000|sign; subnormal results denormalised exactly without rounding.

Reset
REQ-019 Reset (any state, incl. mid-WAIT) SHALL force IDLE and drive req_ready=1 and all other outputs 0, incl. resp_data, resp_flags, ds_a and ds_b.
REQ-020 An engine result arriving after a mid-operation reset SHALL be dropped per REQ-013.

Configuration
REQ-021 Macro FP32_DIVSQRT_ISSUE_TIMEOUT_EN: defined -> 6-bit counter counts WAIT cycles; at 63 with no matching out-valid, go to RESP with resp_data=0x7FC00000, resp_flags=5'b10000, timeout=1 for that one cycle; counter clears on leaving WAIT.
REQ-022 Without the macro: WAIT is unbounded, no counter is present, and timeout is tied 0.

Structure
REQ-023 Shared package SHALL hold the FSM state enum, REC_W=33, EXP_W=8, SIG_W=24, rounding-mode encodings (RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4), flag bit indices.
REQ-024 The IEEE<->recoded conversion SHALL be one combinational sub-module fp32_recode_codec, instantiated for a, b and the result.

Verification
REQ-025 Div 0x40C00000/0x40000000, rm=RNE, engine returns recoded 3.0 -> resp_data 0x40400000, flags 0, resp_sqrt 0.
REQ-026 Sqrt 0x40800000 with ds_in_ready held low 5 cycles -> ds_* stable for 5 cycles, ds_in_valid drops after handshake, resp_data 0x40000000.
REQ-027 Div 0x3F800000/0x00000000, engine flags 01000 and recoded +inf -> resp_data 0x7F800000, resp_flags 5'b01000; ds_a=33'h080000000, ds_b exp field 000.
REQ-028 In WAIT for div, pulse ds_out_valid_sqrt -> ignored, state stays WAIT; resp_ready low 3 cycles in RESP -> response held stable, req_ready=0.
REQ-029 Reset asserted mid-WAIT, then matching out-valid -> no resp_valid, req_ready=1; with macro defined, no out-valid for 63 cycles -> timeout pulse, resp_data 0x7FC00000, resp_flags 5'b10000.

Source files
------------

// File: rtl/fp32_divsqrt_issuer_pkg.sv
// Shared types and constants for the fp32 div/sqrt issuer and its recode codec.
// Recoded format: {sign, 9-bit exponent, 23-bit fraction}; exponent 0x100 encodes 2^0.
package fp32_divsqrt_issuer_pkg;

   localparam int REC_W = 33;
   localparam int EXP_W = 8;
   localparam int SIG_W = 24;

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

   localparam int FLG_NX = 0;
   localparam int FLG_UF = 1;
   localparam int FLG_OF = 2;
   localparam int FLG_DZ = 3;
   localparam int FLG_NV = 4;

   localparam logic [31:0] QNAN         = 32'h7FC0_0000;
   localparam logic [5:0]  WAIT_TIMEOUT = 6'd63;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

endpackage

// File: rtl/fp32_divsqrt_issuer_if.sv
// Request, engine and response signals of the issuer; master = issuer, slave = its environment.
interface fp32_divsqrt_issuer_if;
   import fp32_divsqrt_issuer_pkg::*;

   logic             req_valid;
   logic             req_sqrt;
   logic [2:0]       req_rm;
   logic             req_tininess;
   logic [31:0]      req_a;
   logic [31:0]      req_b;
   logic             req_ready;

   logic             ds_in_valid;
   logic             ds_sqrt;
   logic [2:0]       ds_rm;
   logic             ds_tininess;
   logic [REC_W-1:0] ds_a;
   logic [REC_W-1:0] ds_b;
   logic             ds_in_ready;
   logic             ds_out_valid_div;
   logic             ds_out_valid_sqrt;
   logic [REC_W-1:0] ds_out;
   logic [4:0]       ds_flags;

   logic             resp_valid;
   logic [31:0]      resp_data;
   logic [4:0]       resp_flags;
   logic             resp_sqrt;
   logic             resp_ready;

   logic             busy;
   logic             timeout;

   modport master (
      input  req_valid, req_sqrt, req_rm, req_tininess, req_a, req_b,
      output req_ready,
      output ds_in_valid, ds_sqrt, ds_rm, ds_tininess, ds_a, ds_b,
      input  ds_in_ready, ds_out_valid_div, ds_out_valid_sqrt, ds_out, ds_flags,
      output resp_valid, resp_data, resp_flags, resp_sqrt,
      input  resp_ready,
      output busy, timeout
   );

   modport slave (
      output req_valid, req_sqrt, req_rm, req_tininess, req_a, req_b,
      input  req_ready,
      input  ds_in_valid, ds_sqrt, ds_rm, ds_tininess, ds_a, ds_b,
      output ds_in_ready, ds_out_valid_div, ds_out_valid_sqrt, ds_out, ds_flags,
      input  resp_valid, resp_data, resp_flags, resp_sqrt,
      output resp_ready,
      input  busy, timeout
   );

endinterface

// File: rtl/fp32_recode_codec.sv
// Combinational IEEE fp32 <-> recoded converter; TO_REC selects the direction.
// Decode returns a sign-preserving quiet NaN and denormalises tiny results by plain truncation.
module fp32_recode_codec
   import fp32_divsqrt_issuer_pkg::*;
#(
   parameter bit TO_REC = 1'b1,
   parameter int IN_W   = TO_REC ? 32 : REC_W,
   parameter int OUT_W  = TO_REC ? REC_W : 32
) (
   input  logic [IN_W-1:0]  in_dat,
   output logic [OUT_W-1:0] out_dat
);

   function automatic logic [REC_W-1:0] to_rec(input logic [31:0] f);
      logic [EXP_W-1:0] e;
      logic [SIG_W-2:0] m;
      logic [4:0]       lz;
      logic [EXP_W:0]   er;
      logic [SIG_W-2:0] mr;
      e  = f[30:23];
      m  = f[22:0];
      lz = 5'd0;
      for (int i = 0; i < SIG_W - 1; i++) begin
         if (m[i]) lz = 5'(SIG_W - 2 - i);
      end
      if (e == '1) begin
         er = (m != '0) ? 9'h1C0 : 9'h180;
         mr = m;
      end else if (e == '0 && m == '0) begin
         er = '0;
         mr = '0;
      end else if (e == '0) begin
         // shift the leading one out so the hidden bit is implicit, like a normal
         er = 9'd129 - {4'd0, lz};
         mr = m << (lz + 5'd1);
      end else begin
         er = {1'b0, e} + 9'd129;
         mr = m;
      end
      return {f[31], er, mr};
   endfunction

   function automatic logic [31:0] to_ieee(input logic [REC_W-1:0] r);
      logic [EXP_W:0]   er;
      logic [EXP_W:0]   sh;
      logic [SIG_W-1:0] full;
      logic [31:0]      o;
      er   = r[31:23];
      full = {1'b1, r[22:0]};
      sh   = 9'd130 - er;
      case (er[8:6])
         3'b000:  o = {r[32], 31'd0};
         3'b110:  o = {r[32], 8'hFF, 23'd0};
         3'b111:  o = {r[32], QNAN[30:0]};
         default: begin
            if (er < 9'd130) o = {r[32], 8'd0, (sh >= 9'd24) ? 23'd0 : 23'(full >> sh)};
            else             o = {r[32], 8'(er - 9'd129), r[22:0]};
         end
      endcase
      return o;
   endfunction

   generate
      if (TO_REC) begin : g_enc
         assign out_dat = to_rec(in_dat);
      end else begin : g_dec
         assign out_dat = to_ieee(in_dat);
      end
   endgenerate

endmodule

// File: rtl/fp32_divsqrt_issuer.sv
// Single-outstanding fp32 div/sqrt issuer: ds_in_valid 1 cycle after accept, resp_valid 1 cycle after result.
// Stalls on ds_in_ready/resp_ready; FP32_DIVSQRT_ISSUE_TIMEOUT_EN bounds WAIT at 63 cycles with a qNaN/NV reply.
module fp32_divsqrt_issuer
   import fp32_divsqrt_issuer_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   fp32_divsqrt_issuer_if.master bus
);

   state_t           state_q, state_d;
   logic             sqrt_q, sqrt_d;
   logic [2:0]       rm_q, rm_d;
   logic             tininess_q, tininess_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [31:0]      resp_data_q, resp_data_d;
   logic [4:0]       resp_flags_q, resp_flags_d;
   logic [REC_W-1:0] a_rec, b_rec;
   logic [31:0]      res_ieee;
   logic             result_hit;

`ifdef FP32_DIVSQRT_ISSUE_TIMEOUT_EN
   logic [5:0]       wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;
`endif

   fp32_recode_codec #(.TO_REC(1'b1)) u_rec_a   (.in_dat(a_q),        .out_dat(a_rec));
   fp32_recode_codec #(.TO_REC(1'b1)) u_rec_b   (.in_dat(b_q),        .out_dat(b_rec));
   fp32_recode_codec #(.TO_REC(1'b0)) u_dec_res (.in_dat(bus.ds_out), .out_dat(res_ieee));

   // only the result of the op we issued may complete it
   assign result_hit = sqrt_q ? bus.ds_out_valid_sqrt : bus.ds_out_valid_div;

   always_comb begin
      state_d      = state_q;
      sqrt_d       = sqrt_q;
      rm_d         = rm_q;
      tininess_d   = tininess_q;
      a_d          = a_q;
      b_d          = b_q;
      resp_data_d  = resp_data_q;
      resp_flags_d = resp_flags_q;
`ifdef FP32_DIVSQRT_ISSUE_TIMEOUT_EN
      wait_cnt_d   = '0;
      timeout_d    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               sqrt_d     = bus.req_sqrt;
               rm_d       = bus.req_rm;
               tininess_d = bus.req_tininess;
               a_d        = bus.req_a;
               b_d        = bus.req_b;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus.ds_in_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (result_hit) begin
               resp_data_d  = res_ieee;
               resp_flags_d = bus.ds_flags;
               state_d      = ST_RESP;
            end
`ifdef FP32_DIVSQRT_ISSUE_TIMEOUT_EN
            else if (wait_cnt_q == WAIT_TIMEOUT) begin
               resp_data_d          = QNAN;
               resp_flags_d         = '0;
               resp_flags_d[FLG_NV] = 1'b1;
               timeout_d            = 1'b1;
               state_d              = ST_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + 6'd1;
            end
`endif
         end
         ST_RESP: begin
            if (bus.resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         sqrt_q       <= 1'b0;
         rm_q         <= '0;
         tininess_q   <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         resp_data_q  <= '0;
         resp_flags_q <= '0;
      end else begin
         state_q      <= state_d;
         sqrt_q       <= sqrt_d;
         rm_q         <= rm_d;
         tininess_q   <= tininess_d;
         a_q          <= a_d;
         b_q          <= b_d;
         resp_data_q  <= resp_data_d;
         resp_flags_q <= resp_flags_d;
      end
   end

`ifdef FP32_DIVSQRT_ISSUE_TIMEOUT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end
   assign bus.timeout = timeout_q;
`else
   assign bus.timeout = 1'b0;
`endif

   assign bus.req_ready   = (state_q == ST_IDLE);
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.ds_in_valid = (state_q == ST_ISSUE);
   assign bus.ds_sqrt     = sqrt_q;
   assign bus.ds_rm       = rm_q;
   assign bus.ds_tininess = tininess_q;
   assign bus.ds_a        = a_rec;
   assign bus.ds_b        = b_rec;
   assign bus.resp_valid  = (state_q == ST_RESP);
   assign bus.resp_data   = resp_data_q;
   assign bus.resp_flags  = resp_flags_q;
   assign bus.resp_sqrt   = sqrt_q;

endmodule

// File: tb/tb_fp32_divsqrt_issuer.sv
// Bench for fp32_divsqrt_issuer: directed cases plus random ops against a value-level recode model.
module tb_fp32_divsqrt_issuer;
   import fp32_divsqrt_issuer_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   fp32_divsqrt_issuer_if bus ();

   fp32_divsqrt_issuer dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] want);
      n_chk++;
      if (obs !== want) begin
         n_err++;
         $display("FAIL %s obs=%h want=%h", tag, obs, want);
      end
   endtask

   // Recoded value from the number itself: normalise mantissa*2^exp to 1.f*2^k, exponent field = k+256.
   function automatic logic [32:0] model_rec(input logic [31:0] f);
      int     e;
      longint mant;
      int     ex;
      e = int'(f[30:23]);
      if (e == 255) return {f[31], (f[22:0] != 0) ? 3'b111 : 3'b110, 6'd0, f[22:0]};
      if (e == 0 && f[22:0] == 0) return {f[31], 32'd0};
      if (e == 0) begin
         mant = longint'(f[22:0]);
         ex   = -149;
      end else begin
         mant = longint'(f[22:0]) + (64'd1 << 23);
         ex   = e - 150;
      end
      while (mant < (64'd1 << 23)) begin
         mant = mant * 2;
         ex   = ex - 1;
      end
      return {f[31], 9'(ex + 23 + 256), 23'(mant - (64'd1 << 23))};
   endfunction

   // Bits of the recoded form that carry meaning for each class of input.
   function automatic logic [32:0] rec_mask(input logic [31:0] f);
      if (f[30:23] == 8'hFF) return 33'h1_E07F_FFFF;
      if (f[30:0] == 31'd0)  return 33'h1_E000_0000;
      return '1;
   endfunction

   function automatic logic [31:0] exp_resp(input logic [31:0] f);
      if (f[30:23] == 8'hFF && f[22:0] != 0) return {f[31], 31'h7FC0_0000};
      return f;
   endfunction

   function automatic logic [31:0] rand_fp();
      int   c;
      logic s;
      c = int'($urandom_range(0, 9));
      s = 1'($urandom_range(0, 1));
      case (c)
         0:       return {s, 31'd0};
         1:       return {s, 8'hFF, 23'd0};
         2:       return {s, 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
         3, 4:    return {s, 8'h00, 23'($urandom_range(1, 32'h7F_FFFF))};
         default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
      endcase
   endfunction

   task automatic run_op(input logic sq, input logic [2:0] rm, input logic tin,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [32:0] res_rec, input logic [31:0] want_data,
                         input logic [4:0] flg, input int in_stall, input int eng_dly,
                         input bit wrong_pulse, input int resp_stall);
      @(negedge clock);
      chk("idle_req_ready", 33'(bus.req_ready), 33'(1));
      bus.req_valid    = 1'b1;
      bus.req_sqrt     = sq;
      bus.req_rm       = rm;
      bus.req_tininess = tin;
      bus.req_a        = a;
      bus.req_b        = b;
      @(negedge clock);
      bus.req_valid = 1'b0;
      bus.req_a     = $urandom;
      bus.req_b     = $urandom;
      for (int i = 0; i <= in_stall; i++) begin
         chk("issue_valid", 33'(bus.ds_in_valid), 33'(1));
         chk("issue_req_ready", 33'(bus.req_ready), 33'(0));
         chk("issue_sqrt", 33'(bus.ds_sqrt), 33'(sq));
         chk("issue_rm", 33'(bus.ds_rm), 33'(rm));
         chk("issue_tin", 33'(bus.ds_tininess), 33'(tin));
         chk("issue_a", bus.ds_a & rec_mask(a), model_rec(a) & rec_mask(a));
         if (!sq) chk("issue_b", bus.ds_b & rec_mask(b), model_rec(b) & rec_mask(b));
         if (i == in_stall) bus.ds_in_ready = 1'b1;
         @(negedge clock);
      end
      bus.ds_in_ready = 1'b0;
      chk("wait_in_valid", 33'(bus.ds_in_valid), 33'(0));
      for (int i = 0; i < eng_dly; i++) begin
         if (wrong_pulse && i == 0) begin
            if (sq) bus.ds_out_valid_div = 1'b1;
            else    bus.ds_out_valid_sqrt = 1'b1;
            bus.ds_out = 33'h0_8000_0000;
         end
         @(negedge clock);
         bus.ds_out_valid_div  = 1'b0;
         bus.ds_out_valid_sqrt = 1'b0;
         chk("wait_no_resp", 33'(bus.resp_valid), 33'(0));
         chk("wait_busy", 33'(bus.busy), 33'(1));
      end
      if (sq) bus.ds_out_valid_sqrt = 1'b1;
      else    bus.ds_out_valid_div = 1'b1;
      bus.ds_out   = res_rec;
      bus.ds_flags = flg;
      @(negedge clock);
      bus.ds_out_valid_div  = 1'b0;
      bus.ds_out_valid_sqrt = 1'b0;
      bus.ds_out            = 33'($urandom);
      bus.ds_flags          = 5'($urandom);
      for (int i = 0; i <= resp_stall; i++) begin
         chk("resp_valid", 33'(bus.resp_valid), 33'(1));
         chk("resp_data", 33'(bus.resp_data), 33'(want_data));
         chk("resp_flags", 33'(bus.resp_flags), 33'(flg));
         chk("resp_sqrt", 33'(bus.resp_sqrt), 33'(sq));
         chk("resp_req_ready", 33'(bus.req_ready), 33'(0));
         chk("resp_timeout", 33'(bus.timeout), 33'(0));
         if (i == resp_stall) begin
            bus.resp_ready = 1'b1;
            bus.req_valid  = 1'b1;
         end
         @(negedge clock);
      end
      bus.resp_ready = 1'b0;
      chk("done_resp_valid", 33'(bus.resp_valid), 33'(0));
      chk("done_req_ready", 33'(bus.req_ready), 33'(1));
      chk("done_no_accept", 33'(bus.ds_in_valid), 33'(0));
      bus.req_valid = 1'b0;
   endtask

   task automatic issue_to_wait(input logic sq, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      bus.req_valid   = 1'b1;
      bus.req_sqrt    = sq;
      bus.req_rm      = RM_RNE;
      bus.req_a       = a;
      bus.req_b       = b;
      bus.ds_in_ready = 1'b1;
      @(negedge clock);
      bus.req_valid = 1'b0;
      @(negedge clock);
      bus.ds_in_ready = 1'b0;
      chk("to_wait_busy", 33'(bus.busy), 33'(1));
      chk("to_wait_in_valid", 33'(bus.ds_in_valid), 33'(0));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 33'(bus.req_ready), 33'(1));
      chk({tag, "_busy"}, 33'(bus.busy), 33'(0));
      chk({tag, "_in_valid"}, 33'(bus.ds_in_valid), 33'(0));
      chk({tag, "_resp_valid"}, 33'(bus.resp_valid), 33'(0));
      chk({tag, "_ds_a"}, bus.ds_a, 33'(0));
      chk({tag, "_ds_b"}, bus.ds_b, 33'(0));
      chk({tag, "_resp_data"}, 33'(bus.resp_data), 33'(0));
      chk({tag, "_resp_flags"}, 33'(bus.resp_flags), 33'(0));
      chk({tag, "_timeout"}, 33'(bus.timeout), 33'(0));
   endtask

   initial begin
      logic [31:0] a, b, r;
      int          cyc;
      bus.req_valid = 0; bus.req_sqrt = 0; bus.req_rm = 0; bus.req_tininess = 0;
      bus.req_a = 0; bus.req_b = 0; bus.ds_in_ready = 0; bus.ds_out_valid_div = 0;
      bus.ds_out_valid_sqrt = 0; bus.ds_out = 0; bus.ds_flags = 0; bus.resp_ready = 0;
      #2;
      chk_reset_outputs("por");
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      // 6/2 = 3
      run_op(1'b0, RM_RNE, 1'b0, 32'h40C0_0000, 32'h4000_0000, 33'h0_80C0_0000,
             32'h4040_0000, 5'b00000, 0, 2, 1'b0, 0);
      // sqrt(4) with a 5-cycle issue stall
      run_op(1'b1, RM_RTZ, 1'b1, 32'h4080_0000, 32'h1234_5678, 33'h0_8080_0000,
             32'h4000_0000, 5'b00000, 5, 1, 1'b0, 0);
      // 1/0 -> +inf, DZ; ds_a must be recoded 1.0 and ds_b a zero
      @(negedge clock);
      bus.req_valid = 1'b1; bus.req_sqrt = 1'b0; bus.req_a = 32'h3F80_0000; bus.req_b = 32'h0;
      @(negedge clock);
      bus.req_valid = 1'b0;
      chk("div0_ds_a", bus.ds_a, 33'h0_8000_0000);
      chk("div0_ds_b_exp", 33'(bus.ds_b[31:29]), 33'(0));
      bus.ds_in_ready = 1'b1;
      @(negedge clock);
      bus.ds_in_ready = 1'b0;
      bus.ds_out_valid_div = 1'b1; bus.ds_out = 33'h0_C000_0000; bus.ds_flags = 5'b01000;
      @(negedge clock);
      bus.ds_out_valid_div = 1'b0;
      chk("div0_resp_data", 33'(bus.resp_data), 33'h7F80_0000);
      chk("div0_resp_flags", 33'(bus.resp_flags), 33'(5'b01000));
      bus.resp_ready = 1'b1;
      @(negedge clock);
      bus.resp_ready = 1'b0;
      // wrong-op out-valid in WAIT, response stalled 3 cycles
      run_op(1'b0, RM_RDN, 1'b0, 32'h3F80_0000, 32'h4040_0000, model_rec(32'h3EAA_AAAB),
             32'h3EAA_AAAB, 5'b00001, 1, 3, 1'b1, 3);
      run_op(1'b1, RM_RUP, 1'b0, 32'h0000_0002, 32'h0, model_rec(32'h0008_0000),
             32'h0008_0000, 5'b00011, 0, 2, 1'b1, 1);

      for (int n = 0; n < 24; n++) begin
         a = rand_fp();
         b = rand_fp();
         r = rand_fp();
         run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                a, b, model_rec(r), exp_resp(r), 5'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      // reset while waiting; a late result must be dropped
      issue_to_wait(1'b0, 32'h40C0_0000, 32'h4000_0000);
      reset = 1'b1;
      #1;
      chk_reset_outputs("mid_wait");
      @(negedge clock);
      reset = 1'b0;
      bus.ds_out_valid_div = 1'b1; bus.ds_out = 33'h0_80C0_0000; bus.ds_flags = 5'b00001;
      @(negedge clock);
      bus.ds_out_valid_div = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("late_no_resp", 33'(bus.resp_valid), 33'(0));
         chk("late_req_ready", 33'(bus.req_ready), 33'(1));
         @(negedge clock);
      end

      issue_to_wait(1'b0, 32'h3F80_0000, 32'h3F80_0000);
      cyc = 0;
`ifdef FP32_DIVSQRT_ISSUE_TIMEOUT_EN
      while (!bus.resp_valid && cyc < 100) begin
         @(negedge clock);
         cyc++;
      end
      chk("to_resp_valid", 33'(bus.resp_valid), 33'(1));
      chk("to_min_wait", 33'(cyc >= 62), 33'(1));
      chk("to_pulse", 33'(bus.timeout), 33'(1));
      chk("to_data", 33'(bus.resp_data), 33'h7FC0_0000);
      chk("to_flags", 33'(bus.resp_flags), 33'(5'b10000));
      @(negedge clock);
      chk("to_pulse_end", 33'(bus.timeout), 33'(0));
      chk("to_held", 33'(bus.resp_valid), 33'(1));
`else
      while (cyc < 80) begin
         @(negedge clock);
         cyc++;
      end
      chk("nto_no_resp", 33'(bus.resp_valid), 33'(0));
      chk("nto_timeout", 33'(bus.timeout), 33'(0));
      bus.ds_out_valid_div = 1'b1; bus.ds_out = 33'h0_8000_0000; bus.ds_flags = 5'b00000;
      @(negedge clock);
      bus.ds_out_valid_div = 1'b0;
      chk("nto_resp_valid", 33'(bus.resp_valid), 33'(1));
      chk("nto_resp_data", 33'(bus.resp_data), 33'h3F80_0000);
`endif
      bus.resp_ready = 1'b1;
      @(negedge clock);
      bus.resp_ready = 1'b0;
      chk("end_req_ready", 33'(bus.req_ready), 33'(1));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
